// File: rtl/bht_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : bht_write_arbiter
//  Purpose  : Arbitrates the single BHT write port between ID-stage
//             allocations and EXE-stage counter updates. Allocations always
//             win; updates that cannot be written immediately wait in a small
//             FIFO queue. Each set keeps a 2-bit FIFO victim pointer.
//  Revision : 1.0 - initial release
//
//  Ports
//    CLK, nrst              clock, synchronous active-low reset
//    en, stall              cycle is active when en && !stall
//    alloc_req/set/data     allocation request (written to pointer[set])
//    upd_req/set/way/data   counter update request
//    alloc_way              combinational victim way for alloc_set
//    wr_en/set/way/data     BHT write port (all zero when wr_en=0)
//    q_count                number of queued (valid) updates
//    upd_drop               pulse when an update is discarded
// ============================================================================
module bht_write_arbiter #(
    parameter int QDEPTH = 2,
    parameter int EW     = 22
) (
    input  logic          CLK,
    input  logic          nrst,
    input  logic          en,
    input  logic          stall,
    input  logic          alloc_req,
    input  logic [3:0]    alloc_set,
    input  logic [EW-1:0] alloc_data,
    input  logic          upd_req,
    input  logic [3:0]    upd_set,
    input  logic [1:0]    upd_way,
    input  logic [EW-1:0] upd_data,
    output logic [1:0]    alloc_way,
    output logic          wr_en,
    output logic [3:0]    wr_set,
    output logic [1:0]    wr_way,
    output logic [EW-1:0] wr_data,
    output logic [2:0]    q_count,
    output logic          upd_drop
);

    localparam int IW = $clog2(QDEPTH);

    typedef struct packed {
        logic [3:0]    set;
        logic [1:0]    way;
        logic [EW-1:0] data;
    } ent_t;

    ent_t       q_q [QDEPTH];
    ent_t       q_d [QDEPTH];
    logic [2:0] cnt_q;
    logic [2:0] cnt_d;
    logic [1:0] ptr_q [16];

    logic       active;
    logic [1:0] victim;
    logic       pop;
    logic       bypass;
    logic       killed;
    logic       keep;
    logic [2:0] n;

    assign q_count   = cnt_q;
    assign alloc_way = victim;

    // The queue is kept compacted: valid entries always occupy slots
    // 0..cnt_q-1. Invalidated entries are squeezed out in the same cycle,
    // so an invalid head can never reach the write port.
    always_comb begin
        active   = nrst && en && !stall;
        victim   = ptr_q[alloc_set];
        wr_en    = 1'b0;
        wr_set   = '0;
        wr_way   = '0;
        wr_data  = '0;
        upd_drop = 1'b0;
        pop      = 1'b0;
        bypass   = 1'b0;
        killed   = 1'b0;
        keep     = 1'b0;
        n        = '0;
        cnt_d    = cnt_q;
        for (int i = 0; i < QDEPTH; i++) begin
            q_d[i] = q_q[i];
        end

        if (active) begin
            if (alloc_req) begin
                wr_en   = 1'b1;
                wr_set  = alloc_set;
                wr_way  = victim;
                wr_data = alloc_data;
            end else if (cnt_q != 3'd0) begin
                wr_en   = 1'b1;
                wr_set  = q_q[0].set;
                wr_way  = q_q[0].way;
                wr_data = q_q[0].data;
                pop     = 1'b1;
            end else if (upd_req) begin
                wr_en   = 1'b1;
                wr_set  = upd_set;
                wr_way  = upd_way;
                wr_data = upd_data;
                bypass  = 1'b1;
            end

            // Rebuild the queue: drop the popped head and any entry that the
            // allocation is about to overwrite (its update is now stale).
            for (int i = 0; i < QDEPTH; i++) begin
                keep = (i < int'(cnt_q)) && !(pop && (i == 0));
                if (keep && alloc_req && (q_q[i].set == alloc_set) &&
                    (q_q[i].way == victim)) begin
                    keep   = 1'b0;
                    killed = 1'b1;
                end
                if (keep) begin
                    q_d[n[IW-1:0]] = q_q[i];
                    n              = n + 3'd1;
                end
            end

            if (upd_req && !bypass) begin
                if (alloc_req && (upd_set == alloc_set) && (upd_way == victim)) begin
                    upd_drop = 1'b1;
                end else if (n < 3'(QDEPTH)) begin
                    q_d[n[IW-1:0]] = '{set: upd_set, way: upd_way, data: upd_data};
                    n              = n + 3'd1;
                end else begin
                    upd_drop = 1'b1;
                end
            end

            if (killed) begin
                upd_drop = 1'b1;
            end
            cnt_d = n;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nrst) begin
            cnt_q <= '0;
            for (int i = 0; i < 16; i++) begin
                ptr_q[i] <= '0;
            end
            for (int i = 0; i < QDEPTH; i++) begin
                q_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            for (int i = 0; i < QDEPTH; i++) begin
                q_q[i] <= q_d[i];
            end
            if (active && alloc_req) begin
                ptr_q[alloc_set] <= victim + 2'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bht_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bht_write_arbiter
//  Purpose  : Self-checking bench for bht_write_arbiter. Directed scenarios
//             followed by randomized traffic compared against a queue-based
//             reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bht_write_arbiter;

    localparam int QDEPTH = 2;
    localparam int EW     = 22;

    logic          CLK = 1'b0;
    logic          nrst, en, stall, alloc_req, upd_req;
    logic [3:0]    alloc_set, upd_set;
    logic [1:0]    upd_way;
    logic [EW-1:0] alloc_data, upd_data;
    logic [1:0]    alloc_way;
    logic          wr_en;
    logic [3:0]    wr_set;
    logic [1:0]    wr_way;
    logic [EW-1:0] wr_data;
    logic [2:0]    q_count;
    logic          upd_drop;

    bht_write_arbiter #(.QDEPTH(QDEPTH), .EW(EW)) u_dut (
        .CLK        (CLK),
        .nrst       (nrst),
        .en         (en),
        .stall      (stall),
        .alloc_req  (alloc_req),
        .alloc_set  (alloc_set),
        .alloc_data (alloc_data),
        .upd_req    (upd_req),
        .upd_set    (upd_set),
        .upd_way    (upd_way),
        .upd_data   (upd_data),
        .alloc_way  (alloc_way),
        .wr_en      (wr_en),
        .wr_set     (wr_set),
        .wr_way     (wr_way),
        .wr_data    (wr_data),
        .q_count    (q_count),
        .upd_drop   (upd_drop)
    );

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_chk++;
        if (obs !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, want);
        end
    endtask

    // Reference model: list of pending updates plus per-set victim pointers.
    typedef struct {
        int            set;
        int            way;
        logic [EW-1:0] data;
    } m_ent_t;

    m_ent_t mq[$];
    int     m_ptr[16];

    // Evaluate one cycle: compare outputs against the model, then advance it.
    task automatic cyc();
        logic          e_wr, e_drop;
        int            e_set, e_way, vic;
        logic [EW-1:0] e_data;
        bit            act, bypass, killed;
        m_ent_t        nq[$];
        m_ent_t        ne;
        #1;
        e_wr = 0; e_drop = 0; e_set = 0; e_way = 0; e_data = '0;
        bypass = 0; killed = 0;
        nq  = mq;
        vic = m_ptr[alloc_set];
        act = nrst && en && !stall;
        if (act) begin
            if (alloc_req) begin
                e_wr = 1; e_set = alloc_set; e_way = vic; e_data = alloc_data;
                nq = {};
                foreach (mq[i]) begin
                    if (mq[i].set == int'(alloc_set) && mq[i].way == vic) killed = 1;
                    else nq.push_back(mq[i]);
                end
            end else if (mq.size() > 0) begin
                e_wr = 1; e_set = mq[0].set; e_way = mq[0].way; e_data = mq[0].data;
                void'(nq.pop_front());
            end else if (upd_req) begin
                e_wr = 1; e_set = upd_set; e_way = upd_way; e_data = upd_data;
                bypass = 1;
            end
            if (upd_req && !bypass) begin
                if (alloc_req && upd_set == alloc_set && int'(upd_way) == vic) e_drop = 1;
                else if (nq.size() < QDEPTH) begin
                    ne.set = upd_set; ne.way = upd_way; ne.data = upd_data;
                    nq.push_back(ne);
                end else e_drop = 1;
            end
            if (killed) e_drop = 1;
        end
        check("alloc_way", alloc_way, vic);
        check("wr_en", wr_en, e_wr);
        check("wr_set", wr_set, e_set);
        check("wr_way", wr_way, e_way);
        check("wr_data", wr_data, e_data);
        check("upd_drop", upd_drop, e_drop);
        check("q_count", q_count, mq.size());
        @(posedge CLK);
        if (!nrst) begin
            mq = {};
            foreach (m_ptr[i]) m_ptr[i] = 0;
        end else if (act) begin
            if (alloc_req) m_ptr[alloc_set] = (vic + 1) % 4;
            mq = nq;
        end
        @(negedge CLK);
    endtask

    task automatic drive(input bit a, input int aset, input bit u, input int uset, input int uway);
        alloc_req  = a;
        alloc_set  = 4'(aset);
        alloc_data = EW'($urandom);
        upd_req    = u;
        upd_set    = 4'(uset);
        upd_way    = 2'(uway);
        upd_data   = EW'($urandom);
    endtask

    initial begin
        foreach (m_ptr[i]) m_ptr[i] = 0;
        nrst = 0; en = 1; stall = 0;
        drive(0, 0, 0, 0, 0);
        @(posedge CLK);
        @(negedge CLK);
        cyc();
        nrst = 1;

        // Update alone with empty queue: same-cycle bypass write.
        drive(0, 0, 1, 5, 2);
        #1;
        check("bypass_wr_en", wr_en, 1);
        check("bypass_set", wr_set, 5);
        check("bypass_way", wr_way, 2);
        check("bypass_qcnt", q_count, 0);
        cyc();

        // Allocation wins; the update follows one cycle later.
        drive(1, 3, 1, 7, 1);
        #1;
        check("prio_alloc_set", wr_set, 3);
        check("prio_alloc_way", wr_way, 0);
        cyc();
        drive(0, 3, 0, 0, 0);
        #1;
        check("prio_upd_set", wr_set, 7);
        check("prio_upd_way", wr_way, 1);
        check("prio_ptr3", alloc_way, 1);
        cyc();

        // Victim pointer wraps 3 -> 0.
        for (int k = 0; k < 5; k++) begin
            drive(1, 9, 0, 0, 0);
            #1;
            check("fifo_way", wr_way, k % 4);
            cyc();
        end

        // Queue overflow and FIFO drain.
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 1, 10 + k, k);
            #1;
            check("ovf_drop", upd_drop, (k == 2) ? 1 : 0);
            cyc();
            check("ovf_qcnt", q_count, (k == 0) ? 1 : 2);
        end
        drive(0, 0, 0, 0, 0);
        #1; check("drain0_set", wr_set, 10); cyc();
        #1; check("drain1_set", wr_set, 11); cyc();
        #1; check("drain_idle", wr_en, 0); cyc();

        // Stale entry invalidated by an allocation to the same set/way.
        drive(1, 4, 1, 4, 1);
        cyc();
        check("stale_qcnt1", q_count, 1);
        drive(1, 4, 0, 0, 0);
        #1;
        check("stale_way", wr_way, 1);
        check("stale_drop", upd_drop, 1);
        cyc();
        check("stale_qcnt0", q_count, 0);
        drive(0, 0, 0, 0, 0);
        #1; check("stale_nowr", wr_en, 0); cyc();

        // Stall freezes everything; reset flushes the queue.
        drive(1, 12, 1, 13, 0); cyc();
        drive(1, 12, 1, 13, 1); cyc();
        check("stall_q2", q_count, 2);
        stall = 1;
        drive(1, 12, 1, 13, 3);
        for (int k = 0; k < 3; k++) begin
            #1; check("stall_wr_en", wr_en, 0);
            cyc();
            check("stall_qcnt", q_count, 2);
        end
        stall = 0;
        nrst  = 0;
        drive(0, 0, 0, 0, 0);
        cyc();
        check("rst_qcnt", q_count, 0);
        nrst = 1;
        for (int k = 0; k < 2; k++) begin
            #1; check("rst_nowr", wr_en, 0);
            cyc();
        end

        // Randomized traffic over a few sets to provoke collisions.
        for (int k = 0; k < 600; k++) begin
            en    = ($urandom_range(0, 9) != 0);
            stall = ($urandom_range(0, 6) == 0);
            nrst  = ($urandom_range(0, 99) != 0);
            drive($urandom_range(0, 9) < 3, $urandom_range(0, 2),
                  $urandom_range(0, 1), $urandom_range(0, 2), $urandom_range(0, 3));
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
